uart_rx: RTL

- UART receiver: the receive-direction counterpart of the platform's uart_tx.
- Deserialises 8N1 frames from the host on a single line (LSB first, 1 start, 8 data, 1 stop).
- Presents each received byte on a one-entry holding register with a valid/ack handshake.
- Detects framing errors, overruns and sub-half-bit start glitches. Sits between the board RX pin and a future command decoder that drives platformTop work/enc.

---
 rtl/uart_rx.sv | 83 ++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a one-entry valid/ack holding register,
// framing-error pulse, sticky overrun flag and sub-half-bit start glitch rejection.
module uart_rx #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int UART_BPS = 115200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_rxd,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ack,
   output logic       busy,
   output logic       frame_err,
   output logic       overrun
);
   localparam int BAUD_CNT = CLK_FREQ / UART_BPS;
   localparam int HALF     = BAUD_CNT / 2;
   localparam int CW       = $clog2(BAUD_CNT);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

   state_t          state, state_nx;
   logic            rx_m, rx_s;
   logic [CW-1:0]   cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shift;
   logic            tick_half, tick_full, sample, load, bad_stop;

   assign tick_half = cnt == CW'(HALF - 1);
   assign tick_full = cnt == CW'(BAUD_CNT - 1);

   always_ff @(posedge clk)
      if (!rst_n) begin
         rx_m  <= 1'b1;
         rx_s  <= 1'b1;
         state <= IDLE;
         cnt   <= '0;
      end else begin
         rx_m  <= uart_rxd;
         rx_s  <= rx_m;
         state <= state_nx;
         cnt   <= (state_nx != state || state == IDLE || state == WAIT_IDLE || tick_full) ? '0 : cnt + CW'(1);
      end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (!rx_s) state_nx = START;
         START:     if (tick_half) state_nx = rx_s ? IDLE : DATA;
         DATA:      if (tick_full && bit_idx == 3'd7) state_nx = STOP;
         STOP:      if (tick_full) state_nx = rx_s ? IDLE : WAIT_IDLE;
         WAIT_IDLE: if (rx_s) state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   always_comb begin
      sample   = state == DATA && tick_full;
      load     = state == STOP && tick_full && rx_s;
      bad_stop = state == STOP && tick_full && !rx_s;
   end

   // A load coinciding with an accepted ack replaces the byte without flagging overrun.
   always_ff @(posedge clk)
      if (!rst_n) begin
         bit_idx   <= '0;
         shift     <= '0;
         data      <= '0;
         valid     <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         bit_idx   <= state != DATA ? 3'd0 : sample ? bit_idx + 3'd1 : bit_idx;
         if (sample) shift <= {rx_s, shift[7:1]};
         if (load) data <= shift;
         valid     <= load | (valid & ~ack);
         overrun   <= (load & valid & ~ack) ? 1'b1 : (valid & ack) ? 1'b0 : overrun;
         frame_err <= bad_stop;
         busy      <= state_nx != IDLE;
      end
endmodule
